layer_compositor: RTL and testbench

- Parametrised pipelined pixel compositor that merges LAYERS RGB streams into one VGA output stream.
- Each layer is rendered from the same background timing.
- Replaces the per-state RGB mux and the separate sync delay with one block.
- Adds priority ordering, a transparency colour key, frame-synchronous layer enables and a winning-layer index for hit detection.
- Sits between the layer renderers (background, rect_char, image layers) and the VGA pins.

---
 rtl/layer_compositor.sv | 152 +++++++++++++++
 tb/tb_layer_compositor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: merges LAYERS RGB streams by priority (highest index wins),
// applies a per-layer transparency colour key and delays the VGA timing to match.
// The layer enable mask only changes on a rising edge of vblnk_in, so a frame never tears.
module layer_compositor #(
  parameter int unsigned       LAYERS       = 4,
  parameter int unsigned       COLOR_W      = 12,
  parameter int unsigned       CNT_W        = 11,
  parameter logic [COLOR_W-1:0] BG_COLOR    = '0,
  parameter logic [LAYERS-1:0] LAYER_EN_RST = {{(LAYERS-1){1'b0}}, 1'b1}
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          hcount_in,
  input  logic [CNT_W-1:0]          vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [LAYERS*COLOR_W-1:0] rgb_in,
  input  logic [LAYERS-1:0]         layer_en_in,
  input  logic [LAYERS-1:0]         key_en,
  input  logic [COLOR_W-1:0]        key_color,
  output logic [CNT_W-1:0]          hcount_out,
  output logic [CNT_W-1:0]          vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [COLOR_W-1:0]        rgb_out,
  output logic [2:0]                layer_sel_out,
  output logic [LAYERS-1:0]         layer_en_active,
  output logic                      frame_start
);

  // Mask control
  logic [LAYERS-1:0] layer_en_q;
  logic              frame_start_q;
  logic              armed_q;
  logic              vblnk_rise;

  // Stage 1
  logic [CNT_W-1:0]          hcount_s1_q, vcount_s1_q;
  logic                      hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
  logic [LAYERS*COLOR_W-1:0] rgb_s1_q;
  logic [LAYERS-1:0]         opaque_d, opaque_s1_q;

  // Stage 2
  logic [CNT_W-1:0]   hcount_s2_q, vcount_s2_q;
  logic               hsync_s2_q, vsync_s2_q, hblnk_s2_q, vblnk_s2_q;
  logic [COLOR_W-1:0] rgb_d, rgb_s2_q;
  logic [2:0]         sel_d, sel_s2_q;

  // vblnk_s1_q doubles as the edge-detect history. armed_q suppresses a false edge on the
  // first cycle after reset release when vblnk_in is already high.
  assign vblnk_rise = vblnk_in & ~vblnk_s1_q & armed_q;

  // Commit the requested mask on a vblank rising edge and flag it one cycle later.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      layer_en_q    <= LAYER_EN_RST;
      frame_start_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      armed_q       <= 1'b1;
      frame_start_q <= vblnk_rise;
      if (vblnk_rise) begin
        layer_en_q <= layer_en_in;
      end
    end
  end

  // A layer is opaque when enabled and its pixel is not the keyed transparent colour.
  always_comb begin
    opaque_d = '0;
    for (int i = 0; i < int'(LAYERS); i++) begin
      opaque_d[i] = layer_en_q[i] &
                    ~(key_en[i] & (rgb_in[i*COLOR_W +: COLOR_W] == key_color));
    end
  end

  // Stage 1: capture opacity, raw pixels and timing.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_s1_q <= '0;
      vcount_s1_q <= '0;
      hsync_s1_q  <= 1'b0;
      vsync_s1_q  <= 1'b0;
      hblnk_s1_q  <= 1'b0;
      vblnk_s1_q  <= 1'b0;
      rgb_s1_q    <= '0;
      opaque_s1_q <= '0;
    end else begin
      hcount_s1_q <= hcount_in;
      vcount_s1_q <= vcount_in;
      hsync_s1_q  <= hsync_in;
      vsync_s1_q  <= vsync_in;
      hblnk_s1_q  <= hblnk_in;
      vblnk_s1_q  <= vblnk_in;
      rgb_s1_q    <= rgb_in;
      opaque_s1_q <= opaque_d;
    end
  end

  // Priority select: ascending scan so the highest opaque index overwrites lower ones.
  always_comb begin
    logic [COLOR_W-1:0] win_rgb;
    win_rgb = BG_COLOR;
    sel_d   = '0;
    for (int i = 0; i < int'(LAYERS); i++) begin
      if (opaque_s1_q[i]) begin
        win_rgb = rgb_s1_q[i*COLOR_W +: COLOR_W];
        sel_d   = 3'(i);
      end
    end
    rgb_d = (hblnk_s1_q | vblnk_s1_q) ? '0 : win_rgb;
  end

  // Stage 2: register the composited pixel and the delayed timing.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_s2_q <= '0;
      vcount_s2_q <= '0;
      hsync_s2_q  <= 1'b0;
      vsync_s2_q  <= 1'b0;
      hblnk_s2_q  <= 1'b0;
      vblnk_s2_q  <= 1'b0;
      rgb_s2_q    <= '0;
      sel_s2_q    <= '0;
    end else begin
      hcount_s2_q <= hcount_s1_q;
      vcount_s2_q <= vcount_s1_q;
      hsync_s2_q  <= hsync_s1_q;
      vsync_s2_q  <= vsync_s1_q;
      hblnk_s2_q  <= hblnk_s1_q;
      vblnk_s2_q  <= vblnk_s1_q;
      rgb_s2_q    <= rgb_d;
      sel_s2_q    <= sel_d;
    end
  end

  assign hcount_out      = hcount_s2_q;
  assign vcount_out      = vcount_s2_q;
  assign hsync_out       = hsync_s2_q;
  assign vsync_out       = vsync_s2_q;
  assign hblnk_out       = hblnk_s2_q;
  assign vblnk_out       = vblnk_s2_q;
  assign rgb_out         = rgb_s2_q;
  assign layer_sel_out   = sel_s2_q;
  assign layer_en_active = layer_en_q;
  assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: the driver pushes hand-computed expectations,
// the monitor pops and compares them on the falling edge when they come due.
module tb_layer_compositor;

  localparam logic [11:0] Bg = 12'h5A5;

  logic        pclk, rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [47:0] rgb_in;
  logic [3:0]  layer_en_in, key_en, layer_en_active;
  logic [11:0] key_color, rgb_out;
  logic [2:0]  layer_sel_out;
  logic        frame_start;

  layer_compositor #(.LAYERS(4), .COLOR_W(12), .CNT_W(11), .BG_COLOR(Bg)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .layer_en_in(layer_en_in), .key_en(key_en), .key_color(key_color),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .layer_sel_out(layer_sel_out),
    .layer_en_active(layer_en_active), .frame_start(frame_start)
  );

  typedef struct {
    int unsigned due;
    logic [11:0] rgb;
    logic [2:0]  sel;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
  } px_t;

  typedef struct {
    int unsigned due;
    logic        rz;   // expect every output at its reset value
    logic        fs;
    logic [3:0]  act;
  } ct_t;

  px_t pq[$];
  ct_t cq[$];

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] hc_r = '0;

  localparam logic [47:0] Px   = {12'h444, 12'h333, 12'h222, 12'h111};
  localparam logic [47:0] Key4 = {12'h444, 12'h444, 12'h444, 12'h444};

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: compare whatever is due this cycle.
  always @(negedge pclk) begin
    px_t p;
    ct_t c;
    while (pq.size() > 0 && pq[0].due < cyc) begin
      p = pq.pop_front();
      chk("px_missed", p.due, cyc);
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      chk("rgb_out", rgb_out, p.rgb);
      chk("layer_sel_out", layer_sel_out, p.sel);
      chk("hcount_out", hcount_out, p.hc);
      chk("vcount_out", vcount_out, p.vc);
      chk("hsync_out", hsync_out, p.hs);
      chk("vsync_out", vsync_out, p.vs);
      chk("hblnk_out", hblnk_out, p.hb);
      chk("vblnk_out", vblnk_out, p.vb);
    end
    while (cq.size() > 0 && cq[0].due < cyc) begin
      c = cq.pop_front();
      chk("ctl_missed", c.due, cyc);
    end
    if (cq.size() > 0 && cq[0].due == cyc) begin
      c = cq.pop_front();
      chk("frame_start", frame_start, c.fs);
      chk("layer_en_active", layer_en_active, c.act);
      if (c.rz) begin
        chk("rst_rgb_out", rgb_out, 0);
        chk("rst_layer_sel_out", layer_sel_out, 0);
        chk("rst_hcount_out", hcount_out, 0);
        chk("rst_vcount_out", vcount_out, 0);
        chk("rst_syncs", {hsync_out, vsync_out}, 0);
        chk("rst_blanks", {hblnk_out, vblnk_out}, 0);
      end
    end
  end

  // One pixel per cycle. er/es: composited result 2 cycles later.
  // efs/eact: frame_start and mask just after this cycle's rising edge.
  task automatic drive(input logic hb, input logic vb, input logic [47:0] px,
                       input logic [3:0] en, input logic [3:0] ke, input logic [11:0] kc,
                       input logic [11:0] er, input logic [2:0] es,
                       input logic efs, input logic [3:0] eact);
    @(negedge pclk);
    hc_r        = hc_r + 11'd1;
    hcount_in   = hc_r;
    vcount_in   = hc_r ^ 11'h155;
    hsync_in    = (hc_r % 5 == 0);
    vsync_in    = (hc_r % 7 == 0);
    hblnk_in    = hb;
    vblnk_in    = vb;
    rgb_in      = px;
    layer_en_in = en;
    key_en      = ke;
    key_color   = kc;
    pq.push_back('{due: cyc + 2, rgb: er, sel: es, hc: hcount_in, vc: vcount_in,
                   hs: hsync_in, vs: vsync_in, hb: hb, vb: vb});
    cq.push_back('{due: cyc + 1, rz: 1'b0, fs: efs, act: eact});
  endtask

  task automatic push_reset_check();
    cq.push_back('{due: cyc + 1, rz: 1'b1, fs: 1'b0, act: 4'b0001});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = Px; layer_en_in = 4'b1111; key_en = '0; key_color = '0;

    // Reset state
    @(negedge pclk); push_reset_check();
    @(negedge pclk); push_reset_check();
    @(negedge pclk); rst = 1'b1;

    //    hb vb px    en       ke       kc       rgb     sel fs act
    drive(0, 1, Px,   4'b1111, 4'b0000, 12'h000, 12'h000, 0, 1, 4'b1111); // commit 1111
    for (int i = 0; i < 3; i++)
      drive(0, 0, Px, 4'b1111, 4'b0000, 12'h000, 12'h444, 3, 0, 4'b1111);
    for (int i = 0; i < 2; i++)
      drive(0, 0, Px, 4'b1111, 4'b1000, 12'h444, 12'h333, 2, 0, 4'b1111);
    drive(0, 0, Key4, 4'b1111, 4'b1111, 12'h444, Bg,      0, 0, 4'b1111);
    for (int i = 0; i < 2; i++)
      drive(1, 0, Px, 4'b1111, 4'b0000, 12'h000, 12'h000, 3, 0, 4'b1111);
    drive(0, 0, Px,   4'b1111, 4'b0000, 12'h000, 12'h444, 3, 0, 4'b1111);
    drive(0, 1, Px,   4'b0001, 4'b0000, 12'h000, 12'h000, 3, 1, 4'b0001); // commit 0001
    drive(0, 0, Px,   4'b0001, 4'b0000, 12'h000, 12'h111, 0, 0, 4'b0001);
    drive(0, 0, Px,   4'b0001, 4'b0001, 12'h111, Bg,      0, 0, 4'b0001); // keyed layer 0
    for (int i = 0; i < 3; i++)   // mid-line request must not take effect
      drive(0, 0, Px, 4'b0101, 4'b0000, 12'h000, 12'h111, 0, 0, 4'b0001);
    drive(0, 1, Px,   4'b0101, 4'b0000, 12'h000, 12'h000, 0, 1, 4'b0101); // commit 0101
    drive(0, 1, Px,   4'b0101, 4'b0000, 12'h000, 12'h000, 2, 0, 4'b0101); // held high
    for (int i = 0; i < 2; i++)
      drive(0, 0, Px, 4'b0101, 4'b0000, 12'h000, 12'h333, 2, 0, 4'b0101);

    // Drain, then asynchronous reset between clock edges with vblnk held high.
    repeat (3) @(negedge pclk);
    #2;
    rst = 1'b0;
    vblnk_in = 1'b1;
    layer_en_in = 4'b0110;
    push_reset_check();
    @(negedge pclk); push_reset_check();
    @(negedge pclk); rst = 1'b1;

    drive(0, 1, Px,   4'b0110, 4'b0000, 12'h000, 12'h000, 0, 0, 4'b0001); // no false edge
    drive(0, 1, Px,   4'b0110, 4'b0000, 12'h000, 12'h000, 0, 0, 4'b0001);
    drive(0, 0, Px,   4'b0110, 4'b0000, 12'h000, 12'h111, 0, 0, 4'b0001);
    drive(0, 1, Px,   4'b0110, 4'b0000, 12'h000, 12'h000, 0, 1, 4'b0110); // commit 0110
    for (int i = 0; i < 2; i++)
      drive(0, 0, Px, 4'b0110, 4'b0000, 12'h000, 12'h333, 2, 0, 4'b0110);

    repeat (4) @(negedge pclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
